// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 responder model: FSM states, default
// timings at 100 MHz and the frame checksum used by both ends of the link.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_TURN,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht11_state_e;

  localparam int unsigned DHT11_T_START_MIN = 1_800_000;
  localparam int unsigned DHT11_T_TURN      = 3_000;
  localparam int unsigned DHT11_T_RESP_LOW  = 8_000;
  localparam int unsigned DHT11_T_RESP_HIGH = 8_000;
  localparam int unsigned DHT11_T_BIT_LOW   = 5_000;
  localparam int unsigned DHT11_T_ZERO_HIGH = 2_600;
  localparam int unsigned DHT11_T_ONE_HIGH  = 7_000;
  localparam int unsigned DHT11_T_END_LOW   = 5_000;

  function automatic int unsigned dht11_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Sum modulo 256 of the four payload bytes.
  function automatic logic [7:0] dht11_checksum(input logic [7:0] hum_int,
                                                input logic [7:0] hum_float,
                                                input logic [7:0] temp_int,
                                                input logic [7:0] temp_float);
    return hum_int + hum_float + temp_int + temp_float;
  endfunction

endpackage

// File: rtl/dht11_sensor_model_if.sv
// Control/status bundle of the DHT11 responder model.
interface dht11_sensor_model_if;
  import dht11_pkg::*;

  // EN and the payload bytes are levels sampled by the model; START_SEEN and
  // FRAME_DONE are single-cycle pulses, BUSY is a level between them.
  logic         EN;
  logic [7:0]   HUM_INT;
  logic [7:0]   HUM_FLOAT;
  logic [7:0]   TEMP_INT;
  logic [7:0]   TEMP_FLOAT;
  logic         CRC_CORRUPT;
  logic         BUSY;
  logic         FRAME_DONE;
  logic         START_SEEN;
  dht11_state_e dbg_state;

  modport master (
    output EN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC_CORRUPT,
    input  BUSY, FRAME_DONE, START_SEEN, dbg_state
  );

  modport slave (
    input  EN, HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, CRC_CORRUPT,
    output BUSY, FRAME_DONE, START_SEEN, dbg_state
  );

endinterface

// File: rtl/dht11_sync2.sv
// Two-flop synchronizer for the data line; resets to 1 to match the idle-high bus.
module dht11_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dht11_sensor_model.sv
// DHT11 sensor emulator: detects a host start pulse on the open-drain line and
// answers with the sync pulses and a 40-bit humidity/temperature frame.
module dht11_sensor_model
  import dht11_pkg::*;
#(
  parameter int unsigned T_START_MIN = DHT11_T_START_MIN,
  parameter int unsigned T_TURN      = DHT11_T_TURN,
  parameter int unsigned T_RESP_LOW  = DHT11_T_RESP_LOW,
  parameter int unsigned T_RESP_HIGH = DHT11_T_RESP_HIGH,
  parameter int unsigned T_BIT_LOW   = DHT11_T_BIT_LOW,
  parameter int unsigned T_ZERO_HIGH = DHT11_T_ZERO_HIGH,
  parameter int unsigned T_ONE_HIGH  = DHT11_T_ONE_HIGH,
  parameter int unsigned T_END_LOW   = DHT11_T_END_LOW
) (
  input  logic                 CLK,
  input  logic                 RST,
  inout  wire                  DHT_DATA,
  dht11_sensor_model_if.slave  bus
);

  localparam int unsigned T_MAX =
    dht11_max(dht11_max(dht11_max(T_START_MIN, T_TURN), dht11_max(T_RESP_LOW, T_RESP_HIGH)),
              dht11_max(dht11_max(T_BIT_LOW, T_ZERO_HIGH), dht11_max(T_ONE_HIGH, T_END_LOW)));
  localparam int CW = $clog2(T_MAX) + 1;

  // Phase-end compare values: the state changes on the Nth cycle of a phase.
  localparam logic [CW-1:0] C_START_MIN = CW'(T_START_MIN);
  localparam logic [CW-1:0] C_TURN      = CW'(T_TURN - 1);
  localparam logic [CW-1:0] C_RESP_LOW  = CW'(T_RESP_LOW - 1);
  localparam logic [CW-1:0] C_RESP_HIGH = CW'(T_RESP_HIGH - 1);
  localparam logic [CW-1:0] C_BIT_LOW   = CW'(T_BIT_LOW - 1);
  localparam logic [CW-1:0] C_ZERO_HIGH = CW'(T_ZERO_HIGH - 1);
  localparam logic [CW-1:0] C_ONE_HIGH  = CW'(T_ONE_HIGH - 1);
  localparam logic [CW-1:0] C_END_LOW   = CW'(T_END_LOW - 1);
  localparam logic [CW-1:0] C_ONE       = CW'(1);

  dht11_state_e  state;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_idx;
  logic [39:0]   frame_q;
  logic          drive_low_q;
  logic          busy_q;
  logic          done_q;
  logic          start_q;
  logic          line_s;
  logic [7:0]    csum;

  dht11_sync2 u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (DHT_DATA),
    .q   (line_s)
  );

  assign DHT_DATA = drive_low_q ? 1'b0 : 1'bz;

  assign csum = dht11_checksum(bus.HUM_INT, bus.HUM_FLOAT, bus.TEMP_INT, bus.TEMP_FLOAT)
                ^ {8{bus.CRC_CORRUPT}};

  assign bus.BUSY       = busy_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.START_SEEN = start_q;
  assign bus.dbg_state  = state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame_q     <= '0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // The first low sample already counts toward the host low time.
          if (bus.EN && !line_s) begin
            cnt   <= C_ONE;
            state <= ST_HOST_LOW;
          end
        end
        ST_HOST_LOW: begin
          if (!line_s) begin
            if (cnt < C_START_MIN) cnt <= cnt + 1'b1;
          end else if (cnt >= C_START_MIN) begin
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            frame_q <= {bus.HUM_INT, bus.HUM_FLOAT, bus.TEMP_INT, bus.TEMP_FLOAT, csum};
            cnt     <= '0;
            state   <= ST_TURN;
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_TURN: begin
          if (cnt == C_TURN) begin
            cnt         <= '0;
            drive_low_q <= 1'b1;
            state       <= ST_RESP_LOW;
          end else cnt <= cnt + 1'b1;
        end
        ST_RESP_LOW: begin
          if (cnt == C_RESP_LOW) begin
            cnt         <= '0;
            drive_low_q <= 1'b0;
            state       <= ST_RESP_HIGH;
          end else cnt <= cnt + 1'b1;
        end
        ST_RESP_HIGH: begin
          if (cnt == C_RESP_HIGH) begin
            cnt         <= '0;
            bit_idx     <= 6'd39;
            drive_low_q <= 1'b1;
            state       <= ST_BIT_LOW;
          end else cnt <= cnt + 1'b1;
        end
        ST_BIT_LOW: begin
          if (cnt == C_BIT_LOW) begin
            cnt         <= '0;
            drive_low_q <= 1'b0;
            state       <= ST_BIT_HIGH;
          end else cnt <= cnt + 1'b1;
        end
        ST_BIT_HIGH: begin
          if (cnt == (frame_q[bit_idx] ? C_ONE_HIGH : C_ZERO_HIGH)) begin
            cnt         <= '0;
            drive_low_q <= 1'b1;
            if (bit_idx == 6'd0) begin
              state <= ST_END_LOW;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= ST_BIT_LOW;
            end
          end else cnt <= cnt + 1'b1;
        end
        ST_END_LOW: begin
          if (cnt == C_END_LOW) begin
            cnt         <= '0;
            drive_low_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          cnt         <= '0;
          drive_low_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Directed bench for the DHT11 responder model with shortened phase timings.
module tb_dht11_sensor_model;
  import dht11_pkg::*;

  localparam int TS  = 40;
  localparam int TT  = 3;
  localparam int TRL = 8;
  localparam int TRH = 8;
  localparam int TBL = 5;
  localparam int TZH = 3;
  localparam int TOH = 7;
  localparam int TEL = 5;

  logic CLK = 1'b0;
  logic RST;
  logic host_low;
  wire  dht_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Capture results
  int          runs[$];
  int          start_idx, done_idx, rise_idx, start_cnt, done_cnt, busy_bad;
  int          shape_err, one_runs;
  logic [39:0] got_bits;

  dht11_sensor_model_if bus();

  assign dht_data = host_low ? 1'b0 : 1'bz;
  pullup (dht_data);

  dht11_sensor_model #(
    .T_START_MIN (TS),
    .T_TURN      (TT),
    .T_RESP_LOW  (TRL),
    .T_RESP_HIGH (TRH),
    .T_BIT_LOW   (TBL),
    .T_ZERO_HIGH (TZH),
    .T_ONE_HIGH  (TOH),
    .T_END_LOW   (TEL)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .DHT_DATA (dht_data),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  // ---------------- driver tasks ----------------
  task automatic set_payload(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input logic crc);
    bus.HUM_INT     = a;
    bus.HUM_FLOAT   = b;
    bus.TEMP_INT    = c;
    bus.TEMP_FLOAT  = d;
    bus.CRC_CORRUPT = crc;
  endtask

  task automatic host_start(input int len);
    @(negedge CLK);
    host_low = 1'b1;
    repeat (len) @(negedge CLK);
    host_low = 1'b0;
  endtask

  // Samples the line every negedge after host release and records run lengths.
  task automatic capture(input int max_cyc, input bit perturb);
    logic prev, cur;
    int   run;
    runs.delete();
    start_idx = -1; done_idx = -1; rise_idx = -1;
    start_cnt = 0;  done_cnt = 0;  busy_bad = 0;
    prev = 1'b1; run = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      if (perturb && i == 60) begin
        set_payload(8'h12, 8'h34, 8'h56, 8'h78, 1'b1);
        bus.EN = 1'b0;
      end
      cur = dht_data;
      if (bus.START_SEEN) begin start_cnt++; if (start_idx < 0) start_idx = i; end
      if (bus.FRAME_DONE) begin done_cnt++;  if (done_idx < 0)  done_idx = i;  end
      if (start_idx >= 0 && done_idx < 0 && !bus.BUSY) busy_bad++;
      if ((start_idx < 0 || done_idx >= 0) && bus.BUSY) busy_bad++;
      if (cur == prev) run++;
      else begin
        runs.push_back(run);
        run = 1;
        if (cur) rise_idx = i;
      end
      prev = cur;
      if (done_idx >= 0 && i >= done_idx + 5) break;
    end
    runs.push_back(run);
  endtask

  // Turns the recorded runs into 40 bits and counts any phase of the wrong length.
  task automatic decode();
    int h;
    shape_err = 0; one_runs = 0; got_bits = '0;
    if (runs.size() != 85) begin
      shape_err = 1000;
      return;
    end
    if (runs[0] != TT + 2) shape_err++;
    if (runs[1] != TRL)    shape_err++;
    if (runs[2] != TRH)    shape_err++;
    for (int k = 0; k < 40; k++) begin
      if (runs[3 + 2*k] != TBL) shape_err++;
      h = runs[4 + 2*k];
      if (h == TOH) begin got_bits[39-k] = 1'b1; one_runs++; end
      else if (h != TZH) shape_err++;
    end
    if (runs[83] != TEL) shape_err++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++; if (dht_data !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b want 1", dht_data); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    n_checks++; if (bus.FRAME_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", bus.FRAME_DONE); end
    n_checks++; if (bus.START_SEEN !== 1'b0) begin n_fail++; $display("FAIL reset_start_seen: got %b want 0", bus.START_SEEN); end
    n_checks++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL post_reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
  endtask

  task automatic test_nominal();
    set_payload(8'h37, 8'h00, 8'h18, 8'h03, 1'b0);
    host_start(TS);
    capture(2000, 1'b0);
    decode();
    n_checks++; if (shape_err !== 0) begin n_fail++; $display("FAIL nominal_shape: got %0d bad phases want 0", shape_err); end
    n_checks++; if (got_bits !== 40'h37_00_18_03_52) begin n_fail++; $display("FAIL nominal_bits: got %h want 3700180352", got_bits); end
    n_checks++; if (start_cnt !== 1 || start_idx !== 2) begin n_fail++; $display("FAIL nominal_start_seen: got cnt %0d idx %0d want 1 / 2", start_cnt, start_idx); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL nominal_frame_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (done_idx !== rise_idx) begin n_fail++; $display("FAIL nominal_done_timing: got %0d want %0d", done_idx, rise_idx); end
    n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL nominal_busy: got %0d bad samples want 0", busy_bad); end
  endtask

  task automatic test_short_start();
    host_start(TS - 1);
    capture(200, 1'b0);
    n_checks++; if (start_cnt !== 0) begin n_fail++; $display("FAIL short_start_seen: got %0d want 0", start_cnt); end
    n_checks++; if (runs.size() !== 1) begin n_fail++; $display("FAIL short_line_driven: got %0d runs want 1", runs.size()); end
    n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL short_busy: got %0d bad samples want 0", busy_bad); end
    n_checks++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL short_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
  endtask

  task automatic test_all_ones();
    set_payload(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    host_start(TS);
    capture(2000, 1'b0);
    decode();
    n_checks++; if (shape_err !== 0) begin n_fail++; $display("FAIL ones_shape: got %0d bad phases want 0", shape_err); end
    n_checks++; if (got_bits !== 40'hFF_FF_FF_FF_FC) begin n_fail++; $display("FAIL ones_bits: got %h want FFFFFFFFFC", got_bits); end
    n_checks++; if (one_runs !== 38) begin n_fail++; $display("FAIL ones_high_phases: got %0d want 38", one_runs); end
  endtask

  task automatic test_crc_corrupt();
    set_payload(8'h37, 8'h00, 8'h18, 8'h03, 1'b1);
    host_start(TS);
    capture(2000, 1'b0);
    decode();
    bus.CRC_CORRUPT = 1'b0;
    n_checks++; if (shape_err !== 0) begin n_fail++; $display("FAIL crc_shape: got %0d bad phases want 0", shape_err); end
    n_checks++; if (got_bits !== 40'h37_00_18_03_AD) begin n_fail++; $display("FAIL crc_bits: got %h want 37001803AD", got_bits); end
  endtask

  task automatic test_reset_mid_frame();
    logic prev, cur;
    int   falls;
    set_payload(8'h37, 8'h00, 8'h18, 8'h03, 1'b0);
    host_start(TS);
    prev = 1'b1; falls = 0;
    for (int i = 0; i < 2000 && falls < 22; i++) begin
      @(negedge CLK);
      cur = dht_data;
      if (prev && !cur) falls++;
      prev = cur;
    end
    n_checks++; if (falls !== 22) begin n_fail++; $display("FAIL midreset_reach_bit20: got %0d falls want 22", falls); end
    @(negedge CLK);
    n_checks++; if (dht_data !== 1'b0) begin n_fail++; $display("FAIL midreset_driving: got %b want 0", dht_data); end
    #2 RST = 1'b0;
    #1;
    n_checks++; if (dht_data !== 1'b1) begin n_fail++; $display("FAIL midreset_line: got %b want 1", dht_data); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", bus.BUSY); end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    host_start(TS);
    capture(2000, 1'b0);
    decode();
    n_checks++; if (shape_err !== 0 || got_bits !== 40'h37_00_18_03_52) begin n_fail++; $display("FAIL midreset_reframe: got %h err %0d want 3700180352 err 0", got_bits, shape_err); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL midreset_frame_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_en_low();
    bus.EN = 1'b0;
    host_start(TS);
    capture(200, 1'b0);
    bus.EN = 1'b1;
    n_checks++; if (start_cnt !== 0) begin n_fail++; $display("FAIL en_low_start_seen: got %0d want 0", start_cnt); end
    n_checks++; if (runs.size() !== 1) begin n_fail++; $display("FAIL en_low_line_driven: got %0d runs want 1", runs.size()); end
  endtask

  task automatic test_back_to_back();
    // First frame has its payload, CRC flag and EN changed mid-flight.
    set_payload(8'h37, 8'h00, 8'h18, 8'h03, 1'b0);
    host_start(TS);
    capture(2000, 1'b1);
    decode();
    bus.EN = 1'b1;
    bus.CRC_CORRUPT = 1'b0;
    n_checks++; if (shape_err !== 0 || got_bits !== 40'h37_00_18_03_52) begin n_fail++; $display("FAIL b2b_first: got %h err %0d want 3700180352 err 0", got_bits, shape_err); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 1", done_cnt); end
    host_start(TS);
    capture(2000, 1'b0);
    decode();
    n_checks++; if (shape_err !== 0 || got_bits !== 40'h12_34_56_78_14) begin n_fail++; $display("FAIL b2b_second: got %h err %0d want 1234567814 err 0", got_bits, shape_err); end
    n_checks++; if (busy_bad !== 0 || done_cnt !== 1) begin n_fail++; $display("FAIL b2b_second_status: got busy_bad %0d done %0d want 0 / 1", busy_bad, done_cnt); end
  endtask

  initial begin
    RST      = 1'b0;
    host_low = 1'b0;
    bus.EN   = 1'b1;
    set_payload(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    test_reset();
    test_nominal();
    test_short_start();
    test_all_ones();
    test_crc_corrupt();
    test_reset_mid_frame();
    test_en_low();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
